// File: rtl/tlc_phase_sequencer_pkg.sv
`default_nettype none
// ============================================================================
// Module   : tlc_phase_sequencer_pkg
// Purpose  : Shared definitions for the two-road traffic light controller:
//            phase encodings (also the sel value to the Mux_4x1 stage) and
//            the {red,yellow,green} lamp constants.
// Ports    : none (package)
// Revision : 1.0 - initial release
// ============================================================================
package tlc_phase_sequencer_pkg;

   // The encoding is the phase select seen by the downstream mux, so it must
   // not be reordered.
   typedef enum logic [1:0] {
      S_NS_G = 2'b00,
      S_NS_Y = 2'b01,
      S_EW_G = 2'b10,
      S_EW_Y = 2'b11
   } phase_t;

   localparam logic [2:0] L_RED = 3'b100;
   localparam logic [2:0] L_YEL = 3'b010;
   localparam logic [2:0] L_GRN = 3'b001;

   // Returns {ns_light, ew_light} for a phase.
   function automatic logic [5:0] lamps_for(input phase_t p);
      logic [5:0] lamps;
      lamps = {L_GRN, L_RED};
      case (p)
         S_NS_G: lamps = {L_GRN, L_RED};
         S_NS_Y: lamps = {L_YEL, L_RED};
         S_EW_G: lamps = {L_RED, L_GRN};
         S_EW_Y: lamps = {L_RED, L_YEL};
         default: lamps = {L_GRN, L_RED};
      endcase
      return lamps;
   endfunction

endpackage
`default_nettype wire

// File: rtl/tlc_phase_timer.sv
`default_nettype none
// ============================================================================
// Module   : tlc_phase_timer
// Purpose  : Phase length counter. Clears to 0 on the first cycle of a phase,
//            counts enabled cycles, optionally saturates at limit-1, and flags
//            when the count has reached limit-1.
// Ports    : clk, rst_n     clock / async active-low reset
//            en            count enable (0 = hold)
//            clear         restart from 0 on the next enabled edge
//            saturate      1 = stop at limit-1 instead of counting on
//            limit         phase length in cycles (>=1)
//            cnt           current count
//            at_term       cnt == limit-1
// Revision : 1.0 - initial release
// ============================================================================
module tlc_phase_timer #(
   parameter int CNT_W = 8
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             en,
   input  logic             clear,
   input  logic             saturate,
   input  logic [CNT_W-1:0] limit,
   output logic [CNT_W-1:0] cnt,
   output logic             at_term
);

   logic [CNT_W-1:0] r_cnt;
   logic             w_term;

   assign w_term  = (r_cnt == (limit - CNT_W'(1)));
   assign cnt     = r_cnt;
   assign at_term = w_term;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_cnt <= '0;
      end else if (en) begin
         if (clear) begin
            r_cnt <= '0;
         end else if (!(saturate && w_term)) begin
            r_cnt <= r_cnt + CNT_W'(1);
         end
      end
   end

endmodule
`default_nettype wire

// File: rtl/tlc_phase_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : tlc_phase_sequencer
// Purpose  : Phase sequencer for the NS(main)/EW(side) traffic light.
//            Times NS_G -> NS_Y -> EW_G -> EW_Y, latches EW requests, and
//            drives registered sel, per-road lamps and a phase-start strobe.
// Ports    : clk          clock, rising edge
//            rst_n        async assert, sync release, active low
//            enable       1 = run, 0 = freeze everything
//            ew_req       EW vehicle sensor (level or pulse)
//            sel[1:0]     phase select to the lamp mux (= state encoding)
//            ns_light[2:0]{red,yellow,green} for NS
//            ew_light[2:0]{red,yellow,green} for EW
//            phase_start  high in the first cycle of each new phase
// Revision : 1.0 - initial release
// ============================================================================
module tlc_phase_sequencer
   import tlc_phase_sequencer_pkg::*;
#(
   parameter int CNT_W     = 8,
   parameter int GREEN_MIN = 8,
   parameter int EW_GREEN  = 6,
   parameter int YELLOW    = 3
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       enable,
   input  logic       ew_req,
   output logic [1:0] sel,
   output logic [2:0] ns_light,
   output logic [2:0] ew_light,
   output logic       phase_start
);

   localparam logic [CNT_W-1:0] c_lim_ns_g = CNT_W'(GREEN_MIN);
   localparam logic [CNT_W-1:0] c_lim_ew_g = CNT_W'(EW_GREEN);
   localparam logic [CNT_W-1:0] c_lim_yel  = CNT_W'(YELLOW);

   phase_t           r_state;
   phase_t           w_next;
   logic             r_req_pend;
   logic [2:0]       r_ns_light;
   logic [2:0]       r_ew_light;
   logic             r_phase_start;
   logic             w_advance;
   logic [CNT_W-1:0] w_limit;
   logic [CNT_W-1:0] w_cnt;
   logic             w_term;
   logic [5:0]       w_next_lamps;

   // Only NS green saturates; the other phases always leave at their term.
   tlc_phase_timer #(
      .CNT_W (CNT_W)
   ) u_timer (
      .clk      (clk),
      .rst_n    (rst_n),
      .en       (enable),
      .clear    (w_advance),
      .saturate (r_state == S_NS_G),
      .limit    (w_limit),
      .cnt      (w_cnt),
      .at_term  (w_term)
   );

   always_comb begin
      w_limit = c_lim_ns_g;
      case (r_state)
         S_NS_G:  w_limit = c_lim_ns_g;
         S_NS_Y:  w_limit = c_lim_yel;
         S_EW_G:  w_limit = c_lim_ew_g;
         S_EW_Y:  w_limit = c_lim_yel;
         default: w_limit = c_lim_ns_g;
      endcase
   end

   // Next-state: a same-cycle ew_req is enough to leave a saturated NS green.
   always_comb begin
      w_next    = r_state;
      w_advance = 1'b0;
      if (enable) begin
         case (r_state)
            S_NS_G: if (w_term && (r_req_pend || ew_req)) begin
               w_next    = S_NS_Y;
               w_advance = 1'b1;
            end
            S_NS_Y: if (w_term) begin
               w_next    = S_EW_G;
               w_advance = 1'b1;
            end
            S_EW_G: if (w_term) begin
               w_next    = S_EW_Y;
               w_advance = 1'b1;
            end
            S_EW_Y: if (w_term) begin
               w_next    = S_NS_G;
               w_advance = 1'b1;
            end
            default: begin
               w_next    = S_NS_G;
               w_advance = 1'b1;
            end
         endcase
      end
   end

   assign w_next_lamps = lamps_for(w_next);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state       <= S_NS_G;
         r_req_pend    <= 1'b0;
         r_ns_light    <= L_GRN;
         r_ew_light    <= L_RED;
         r_phase_start <= 1'b0;
      end else begin
         r_state       <= w_next;
         r_ns_light    <= w_next_lamps[5:3];
         r_ew_light    <= w_next_lamps[2:0];
         r_phase_start <= w_advance;
         // Entering EW green serves the request; that wins over a new one
         // arriving in the last NS yellow cycle.
         if (enable) begin
            if (w_advance && (w_next == S_EW_G)) begin
               r_req_pend <= 1'b0;
            end else if (ew_req && ((r_state == S_NS_G) || (r_state == S_NS_Y))) begin
               r_req_pend <= 1'b1;
            end
         end
      end
   end

   assign sel         = r_state;
   assign ns_light    = r_ns_light;
   assign ew_light    = r_ew_light;
   assign phase_start = r_phase_start;

endmodule
`default_nettype wire

// File: tb/tb_tlc_phase_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : tb_tlc_phase_sequencer
// Purpose  : Self-checking bench for tlc_phase_sequencer with a phase/age
//            reference model, directed scenarios and random stimulus.
// Revision : 1.0 - initial release
// ============================================================================
module tb_tlc_phase_sequencer;

   localparam int GREEN_MIN = 8;
   localparam int EW_GREEN  = 6;
   localparam int YELLOW    = 3;

   logic       clk = 1'b0;
   logic       rst_n = 1'b0;
   logic       enable = 1'b0;
   logic       ew_req = 1'b0;
   logic [1:0] sel;
   logic [2:0] ns_light;
   logic [2:0] ew_light;
   logic       phase_start;

   tlc_phase_sequencer #(
      .CNT_W     (8),
      .GREEN_MIN (GREEN_MIN),
      .EW_GREEN  (EW_GREEN),
      .YELLOW    (YELLOW)
   ) dut (
      .clk         (clk),
      .rst_n       (rst_n),
      .enable      (enable),
      .ew_req      (ew_req),
      .sel         (sel),
      .ns_light    (ns_light),
      .ew_light    (ew_light),
      .phase_start (phase_start)
   );

   always #5 clk = ~clk;

   int n_checks = 0;
   int n_errors = 0;
   int ps_seen  = 0;

   // Reference model: phase index 0..3 (NS_G, NS_Y, EW_G, EW_Y), cycles spent
   // in the phase so far, and whether an EW request is waiting.
   int m_phase = 0;
   int m_age   = 0;
   bit m_pend  = 0;
   bit m_ps    = 0;
   int dur[4]  = '{GREEN_MIN, YELLOW, EW_GREEN, YELLOW};

   task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] expv);
      n_checks++;
      if (obs !== expv) begin
         n_errors++;
         $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, expv, $time);
      end
   endtask

   function automatic logic [2:0] exp_ns(input int p);
      return (p == 0) ? 3'b001 : (p == 1) ? 3'b010 : 3'b100;
   endfunction

   function automatic logic [2:0] exp_ew(input int p);
      return (p == 2) ? 3'b001 : (p == 3) ? 3'b010 : 3'b100;
   endfunction

   task automatic model_reset();
      m_phase = 0; m_age = 0; m_pend = 0; m_ps = 0;
   endtask

   task automatic model_step(input bit en, input bit req);
      bit leave;
      if (!en) begin
         m_ps = 0;
         return;
      end
      if (m_phase == 0) leave = (m_age >= GREEN_MIN - 1) && (m_pend || req);
      else              leave = (m_age == dur[m_phase] - 1);
      if (m_phase <= 1 && req) m_pend = 1;
      if (leave) begin
         m_phase = (m_phase + 1) % 4;
         m_age   = 0;
         if (m_phase == 2) m_pend = 0;
      end else begin
         m_age++;
      end
      m_ps = leave;
   endtask

   task automatic check_all();
      int ecnt;
      ecnt = (m_phase == 0 && m_age > GREEN_MIN - 1) ? GREEN_MIN - 1 : m_age;
      check("sel",         8'(sel),              8'(m_phase));
      check("ns_light",    8'(ns_light),         8'(exp_ns(m_phase)));
      check("ew_light",    8'(ew_light),         8'(exp_ew(m_phase)));
      check("phase_start", 8'(phase_start),      8'(m_ps));
      check("cnt",         dut.u_timer.cnt,      8'(ecnt));
      check("req_pend",    8'(dut.r_req_pend),   8'(m_pend));
      check("both_nonred", 8'(ns_light != 3'b100 && ew_light != 3'b100), 8'd0);
   endtask

   // Inputs change 1ns after the rising edge; outputs sampled at that point.
   task automatic cycle(input bit en, input bit req);
      enable = en;
      ew_req = req;
      model_step(en, req);
      @(posedge clk); #1;
      if (phase_start === 1'b1) ps_seen++;
      check_all();
   endtask

   // Reset asserted mid-cycle must act immediately; release is away from the edge.
   task automatic reset_mid();
      #3 rst_n = 1'b0;
      #1;
      check("rst_sel", 8'(sel),         8'd0);
      check("rst_ns",  8'(ns_light),    8'h01);
      check("rst_ew",  8'(ew_light),    8'h04);
      check("rst_ps",  8'(phase_start), 8'd0);
      check("rst_pnd", 8'(dut.r_req_pend), 8'd0);
      model_reset();
      @(posedge clk); #1;
      rst_n = 1'b1;
   endtask

   initial begin
      int len;
      int nonzero;
      int k;

      // 1: power-on reset
      @(posedge clk); #1;
      check("por_sel", 8'(sel),         8'd0);
      check("por_ns",  8'(ns_light),    8'h01);
      check("por_ew",  8'(ew_light),    8'h04);
      check("por_ps",  8'(phase_start), 8'd0);
      rst_n = 1'b1;
      model_reset();

      // 2: idle, no request
      ps_seen = 0;
      for (int i = 0; i < 100; i++) cycle(1, 0);
      check("idle_ps_count", 8'(ps_seen), 8'd0);
      check("idle_sat",      dut.u_timer.cnt, 8'd7);

      // 3: early request pulse at cnt=2, full cycle back to NS_G
      reset_mid();
      cycle(1, 0);
      cycle(1, 0);
      ps_seen = 0;
      cycle(1, 1);
      for (int i = 0; i < 4; i++) cycle(1, 0);
      check("early_still_nsg", 8'(sel), 8'd0);
      cycle(1, 0);
      check("early_nsy", 8'(sel), 8'd1);
      for (int i = 0; i < 3 + 6 + 3 + 2; i++) cycle(1, 0);
      check("early_back_nsg",  8'(sel),     8'd0);
      check("early_ps_count",  8'(ps_seen), 8'd4);

      // 4: late request once counter saturated
      reset_mid();
      for (int i = 0; i < 20; i++) cycle(1, 0);
      cycle(1, 1);
      check("late_nsy", 8'(sel), 8'd1);

      // 5: freeze 5 cycles at EW_G cnt=2
      k = 0;
      while (sel != 2'b10 && k < 20) begin cycle(1, 0); k++; end
      check("reach_ewg", 8'(sel), 8'd2);
      len = 1;
      cycle(1, 0); len++;
      cycle(1, 0); len++;
      for (int i = 0; i < 5; i++) begin
         cycle(0, $urandom_range(0, 1));
         if (sel == 2'b10) len++;
      end
      k = 0;
      while (k < 30) begin
         cycle(1, 0);
         if (sel != 2'b10) break;
         len++; k++;
      end
      check("freeze_ewg_len", 8'(len), 8'd11);

      // 6: request held through EW phases is discarded
      reset_mid();
      k = 0;
      while (sel != 2'b10 && k < 40) begin cycle(1, 1); k++; end
      check("disc_reach_ewg", 8'(sel), 8'd2);
      k = 0;
      while (sel != 2'b00 && k < 40) begin cycle(1, 1); k++; end
      check("disc_back_nsg", 8'(sel), 8'd0);
      nonzero = 0;
      for (int i = 0; i < 110; i++) begin
         cycle(1, 0);
         if (sel != 2'b00) nonzero++;
      end
      check("disc_hold_nsg", 8'(nonzero), 8'd0);

      // 6b: reset during EW_Y, and a pending request lost on reset
      cycle(1, 1);
      k = 0;
      while (sel != 2'b11 && k < 40) begin cycle(1, 0); k++; end
      check("reach_ewy", 8'(sel), 8'd3);
      reset_mid();
      cycle(1, 1);
      reset_mid();
      nonzero = 0;
      for (int i = 0; i < 20; i++) begin
         cycle(1, 0);
         if (sel != 2'b00) nonzero++;
      end
      check("lost_pend_hold", 8'(nonzero), 8'd0);

      // Random traffic with random freezes
      for (int i = 0; i < 1500; i++) begin
         cycle(($urandom % 8) != 0, ($urandom % 12) == 0);
         if (($urandom % 400) == 0) reset_mid();
      end

      $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
      $finish;
   end

endmodule
`default_nettype wire
